// File: rtl/struct_pkg.sv
// Shared types and encodings for the RV32I execute stage: opcodes, funct codes,
// ALU op codes, the ALU in/out bundles, the EX control word and the MUL FSM states.
package struct_pkg;

  localparam int DW = 32;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] B_TYPE = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;

  localparam logic [6:0] F7_MUL = 7'b0000001;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    alu_op;
  } alu_in_t;

  typedef struct packed {
    logic [DW-1:0] result;
    logic          n;
    logic          z;
    logic          c;
    logic          v;
  } alu_out_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic rsvd;
    logic branch;
  } ex_ctrl_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU: operands and op code in, result plus {N,Z,C,V} out.
module alu
  import struct_pkg::*;
(
  input  alu_in_t  i_in,
  output alu_out_t o_out
);

  logic [DW:0] w_sum;
  logic [DW:0] w_diff;

  assign w_sum  = {1'b0, i_in.a} + {1'b0, i_in.b};
  assign w_diff = {1'b0, i_in.a} - {1'b0, i_in.b};

  // NOTE: o_out gets a full default first so no path through the case can infer a latch.
  always_comb begin
    o_out = '0;
    case (i_in.alu_op)
      ALU_ADD: begin
        o_out.result = w_sum[DW-1:0];
        o_out.c      = w_sum[DW];
        o_out.v      = (i_in.a[DW-1] == i_in.b[DW-1]) && (w_sum[DW-1] != i_in.a[DW-1]);
      end
      ALU_SUB: begin
        o_out.result = w_diff[DW-1:0];
        o_out.c      = ~w_diff[DW];  // no borrow out means A >= B unsigned
        o_out.v      = (i_in.a[DW-1] != i_in.b[DW-1]) && (w_diff[DW-1] != i_in.a[DW-1]);
      end
      ALU_AND:   o_out.result = i_in.a & i_in.b;
      ALU_OR:    o_out.result = i_in.a | i_in.b;
      ALU_XOR:   o_out.result = i_in.a ^ i_in.b;
      ALU_SLL:   o_out.result = i_in.a << i_in.b[4:0];
      ALU_SRL:   o_out.result = i_in.a >> i_in.b[4:0];
      ALU_SRA:   o_out.result = $unsigned($signed(i_in.a) >>> i_in.b[4:0]);
      ALU_SLT:   o_out.result = {{(DW-1){1'b0}}, $signed(i_in.a) < $signed(i_in.b)};
      ALU_SLTU:  o_out.result = {{(DW-1){1'b0}}, i_in.a < i_in.b};
      ALU_PASSB: o_out.result = i_in.b;
      default:   o_out.result = '0;
    endcase
    o_out.n = o_out.result[DW-1];
    o_out.z = (o_out.result == '0);
  end

endmodule

// File: rtl/ex_mem_stage.sv
// RV32I execute stage plus EX/MEM register: forwarding, ALU, branch resolution.
// Define EX_MUL_EN to add the iterative shift-add multiplier (R-type MUL).
module ex_mem_stage
  import struct_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_CYC = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            idex_valid,
  input  logic [6:0]      idex_op,
  input  logic [2:0]      idex_f3,
  input  logic [6:0]      idex_f7,
  input  logic [3:0]      idex_alu_op,
  input  logic [4:0]      idex_ctrl,
  input  logic [XLEN-1:0] idex_rs1_data,
  input  logic [XLEN-1:0] idex_rs2_data,
  input  logic [XLEN-1:0] idex_imm,
  input  logic [XLEN-1:0] idex_pc,
  input  logic [4:0]      idex_rd,
  input  logic [1:0]      forwardA,
  input  logic [1:0]      forwardB,
  input  logic [XLEN-1:0] memwb_data,
  input  logic            mem_stall,
  output logic            ex_stall,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            exmem_valid,
  output logic [XLEN-1:0] exmem_result,
  output logic [XLEN-1:0] exmem_store,
  output logic [4:0]      exmem_rd,
  output logic [4:0]      exmem_ctrl,
  output logic [3:0]      exmem_flags
);

  logic            r_exmem_valid;
  logic [XLEN-1:0] r_exmem_result;
  logic [XLEN-1:0] r_exmem_store;
  logic [4:0]      r_exmem_rd;
  ex_ctrl_t        r_exmem_ctrl;
  logic [3:0]      r_exmem_flags;

  logic [XLEN-1:0] w_fwd_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_op_b;
  logic            w_cond;
  logic            w_ex_busy;
  logic            w_cap_valid;
  alu_in_t         w_alu_in;
  alu_out_t        w_alu_out;
  alu_out_t        w_res;

  // Code 01 reads the live EX/MEM register, which is exactly what a stall holds.
  always_comb begin
    case (forwardA)
      2'b01:   w_fwd_a = r_exmem_result;
      2'b10:   w_fwd_a = memwb_data;
      default: w_fwd_a = idex_rs1_data;
    endcase
    case (forwardB)
      2'b01:   w_fwd_b = r_exmem_result;
      2'b10:   w_fwd_b = memwb_data;
      default: w_fwd_b = idex_rs2_data;
    endcase
  end

  assign w_op_b   = (idex_op == R_TYPE || idex_op == B_TYPE) ? w_fwd_b : idex_imm;
  assign w_alu_in = '{a: w_fwd_a, b: w_op_b, alu_op: idex_alu_op};

  alu u_alu (
    .i_in  (w_alu_in),
    .o_out (w_alu_out)
  );

  always_comb begin
    case (idex_f3)
      F3_BEQ:  w_cond = (w_fwd_a == w_fwd_b);
      F3_BNE:  w_cond = (w_fwd_a != w_fwd_b);
      F3_BLT:  w_cond = ($signed(w_fwd_a) <  $signed(w_fwd_b));
      F3_BGE:  w_cond = ($signed(w_fwd_a) >= $signed(w_fwd_b));
      F3_BLTU: w_cond = (w_fwd_a <  w_fwd_b);
      F3_BGEU: w_cond = (w_fwd_a >= w_fwd_b);
      default: w_cond = 1'b0;
    endcase
  end

  assign branch_taken  = (idex_op == B_TYPE) && w_cond && idex_valid && !w_ex_busy;
  assign branch_target = idex_pc + idex_imm;

`ifdef EX_MUL_EN
  localparam int CNT_W = $clog2(MUL_CYC);

  mul_state_t      r_mul_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_mul_a;
  logic [XLEN-1:0] r_mul_b;
  logic [XLEN-1:0] r_prod;
  logic            w_is_mul;

  assign w_is_mul  = idex_valid && (idex_op == R_TYPE) && (idex_f7 == F7_MUL) && (idex_f3 == 3'b000);
  assign w_ex_busy = (r_mul_state == IDLE && w_is_mul) || (r_mul_state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_state <= IDLE;
      r_cnt       <= '0;
    end else begin
      case (r_mul_state)
        IDLE: if (w_is_mul) begin
          r_mul_state <= RUN;
          r_cnt       <= '0;
        end
        RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(MUL_CYC - 1)) r_mul_state <= DONE;
        end
        DONE:    if (!mem_stall) r_mul_state <= IDLE;
        default: r_mul_state <= IDLE;
      endcase
    end
  end

  // NOTE: the multiplier datapath carries no reset; IDLE always reloads it before RUN uses it.
  always_ff @(posedge clk) begin
    if (r_mul_state == IDLE) begin
      r_mul_a <= w_fwd_a;
      r_mul_b <= w_fwd_b;
      r_prod  <= '0;
    end else if (r_mul_state == RUN) begin
      if (r_mul_b[0]) r_prod <= r_prod + r_mul_a;
      r_mul_a <= r_mul_a << 1;
      r_mul_b <= r_mul_b >> 1;
    end
  end

  always_comb begin
    w_res = w_alu_out;
    if (r_mul_state == DONE) begin
      w_res        = '0;
      w_res.result = r_prod;
      w_res.n      = r_prod[XLEN-1];
      w_res.z      = (r_prod == '0);
    end
  end
`else
  logic w_unused;

  assign w_ex_busy = 1'b0;
  assign w_res     = w_alu_out;
  assign w_unused  = ^{idex_f7, MUL_CYC[0]};
`endif

  assign ex_stall    = mem_stall || w_ex_busy;
  assign w_cap_valid = idex_valid && !w_ex_busy;

  // NOTE: non-blocking so every EX/MEM field samples the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exmem_valid  <= 1'b0;
      r_exmem_result <= '0;
      r_exmem_store  <= '0;
      r_exmem_rd     <= '0;
      r_exmem_ctrl   <= '0;
      r_exmem_flags  <= '0;
    end else if (!mem_stall) begin
      r_exmem_valid  <= w_cap_valid;
      r_exmem_result <= w_res.result;
      r_exmem_store  <= w_fwd_b;
      r_exmem_rd     <= idex_rd;
      r_exmem_ctrl   <= w_cap_valid ? ex_ctrl_t'(idex_ctrl) : '0;
      r_exmem_flags  <= {w_res.n, w_res.z, w_res.c, w_res.v};
    end
  end

  assign exmem_valid  = r_exmem_valid;
  assign exmem_result = r_exmem_result;
  assign exmem_store  = r_exmem_store;
  assign exmem_rd     = r_exmem_rd;
  assign exmem_ctrl   = r_exmem_ctrl;
  assign exmem_flags  = r_exmem_flags;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: random ALU/forwarding/branch traffic against an arithmetic
// reference model, plus directed stall, reset and multiplier scenarios.
module tb_ex_mem_stage;
  import struct_pkg::*;

  localparam longint S_MAX = 64'sd2147483647;
  localparam longint S_MIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst;
  logic        idex_valid;
  logic [6:0]  idex_op;
  logic [2:0]  idex_f3;
  logic [6:0]  idex_f7;
  logic [3:0]  idex_alu_op;
  logic [4:0]  idex_ctrl;
  logic [31:0] idex_rs1_data;
  logic [31:0] idex_rs2_data;
  logic [31:0] idex_imm;
  logic [31:0] idex_pc;
  logic [4:0]  idex_rd;
  logic [1:0]  forwardA;
  logic [1:0]  forwardB;
  logic [31:0] memwb_data;
  logic        mem_stall;
  logic        ex_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        exmem_valid;
  logic [31:0] exmem_result;
  logic [31:0] exmem_store;
  logic [4:0]  exmem_rd;
  logic [4:0]  exmem_ctrl;
  logic [3:0]  exmem_flags;

  int checks   = 0;
  int failures = 0;

  logic [3:0] ops [11] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
                           ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB};

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .idex_valid    (idex_valid),
    .idex_op       (idex_op),
    .idex_f3       (idex_f3),
    .idex_f7       (idex_f7),
    .idex_alu_op   (idex_alu_op),
    .idex_ctrl     (idex_ctrl),
    .idex_rs1_data (idex_rs1_data),
    .idex_rs2_data (idex_rs2_data),
    .idex_imm      (idex_imm),
    .idex_pc       (idex_pc),
    .idex_rd       (idex_rd),
    .forwardA      (forwardA),
    .forwardB      (forwardB),
    .memwb_data    (memwb_data),
    .mem_stall     (mem_stall),
    .ex_stall      (ex_stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .exmem_valid   (exmem_valid),
    .exmem_result  (exmem_result),
    .exmem_store   (exmem_store),
    .exmem_rd      (exmem_rd),
    .exmem_ctrl    (exmem_ctrl),
    .exmem_flags   (exmem_flags)
  );

  // Reference ALU: returns {result, N, Z, C, V} from plain integer arithmetic.
  function automatic logic [35:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0]     r;
    logic            c;
    logic            v;
    longint          s;
    longint unsigned u;
    logic [4:0]      sh;
    r  = '0;
    c  = 1'b0;
    v  = 1'b0;
    sh = b[4:0];
    case (op)
      ALU_ADD: begin
        r = a + b;
        u = longint'(a) + longint'(b);
        c = (u > 64'hFFFF_FFFF);
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s > S_MAX) || (s < S_MIN);
      end
      ALU_SUB: begin
        r = a - b;
        c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s > S_MAX) || (s < S_MIN);
      end
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_XOR:   r = a ^ b;
      ALU_SLL:   r = a << sh;
      ALU_SRL:   r = a >> sh;
      ALU_SRA:   r = 32'($signed(a) >>> sh);
      ALU_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
      ALU_PASSB: r = b;
      default:   r = '0;
    endcase
    return {r, r[31], (r == 32'd0), c, v};
  endfunction

  function automatic logic model_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    idex_valid = 1'b0; idex_op = I_TYPE; idex_f3 = 3'b000; idex_f7 = 7'b0;
    idex_alu_op = ALU_ADD; idex_ctrl = 5'b0; idex_rs1_data = '0; idex_rs2_data = '0;
    idex_imm = '0; idex_pc = '0; idex_rd = 5'd0; forwardA = 2'b00; forwardB = 2'b00;
    memwb_data = '0; mem_stall = 1'b0;
  endtask

  task automatic drive(input logic [6:0] op, input logic [3:0] aop, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm);
    idex_valid = 1'b1; idex_op = op; idex_alu_op = aop;
    idex_rs1_data = a; idex_rs2_data = b; idex_imm = imm;
  endtask

  task automatic test_reset();
    set_idle();
    drive(R_TYPE, ALU_ADD, 32'($urandom), 32'($urandom), 32'($urandom));
    idex_ctrl = 5'b11111; idex_rd = 5'd7; rst = 1'b1;
    tick(); tick();
    checks++;
    if ({exmem_valid, exmem_result, exmem_store, exmem_rd, exmem_ctrl, exmem_flags} !== '0) begin
      failures++;
      $display("FAIL reset_state: valid=%0d result=%h store=%h rd=%0d ctrl=%b flags=%b, want all 0",
               exmem_valid, exmem_result, exmem_store, exmem_rd, exmem_ctrl, exmem_flags);
    end
    checks++;
    if (ex_stall !== 1'b0) begin
      failures++; $display("FAIL reset_ex_stall: got %b want 0", ex_stall);
    end
    rst = 1'b0;
    set_idle();
  endtask

  task automatic test_directed();
    set_idle();
    drive(R_TYPE, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'h0);
    idex_ctrl = 5'b00100; idex_rd = 5'd5;
    tick();
    checks++;
    if ({exmem_valid, exmem_result, exmem_flags, exmem_ctrl, exmem_rd} !== {1'b1, 32'h0, 4'b0110, 5'b00100, 5'd5}) begin
      failures++;
      $display("FAIL add_carry: valid=%0d result=%h flags=%b ctrl=%b rd=%0d want 1 00000000 0110 00100 5",
               exmem_valid, exmem_result, exmem_flags, exmem_ctrl, exmem_rd);
    end
    drive(R_TYPE, ALU_ADD, 32'h8000_0000, 32'h0, 32'h0);
    tick();
    drive(R_TYPE, ALU_SUB, 32'hDEAD_BEEF, 32'd1, 32'h0);
    forwardA = 2'b01;
    tick();
    checks++;
    if ({exmem_result, exmem_flags} !== {32'h7FFF_FFFF, 4'b0011}) begin
      failures++;
      $display("FAIL sub_fwd_exmem: result=%h flags=%b want 7fffffff 0011", exmem_result, exmem_flags);
    end
    drive(R_TYPE, ALU_ADD, 32'd5, 32'h0BAD_0BAD, 32'h0);
    forwardA = 2'b00; forwardB = 2'b10; memwb_data = 32'h10;
    tick();
    checks++;
    if ({exmem_result, exmem_store} !== {32'h15, 32'h10}) begin
      failures++;
      $display("FAIL fwd_memwb: result=%h store=%h want 00000015 00000010", exmem_result, exmem_store);
    end
    drive(I_TYPE, ALU_ADD, 32'd4, 32'h999, 32'd3);
    forwardB = 2'b00;
    tick();
    checks++;
    if ({exmem_result, exmem_store} !== {32'h7, 32'h999}) begin
      failures++;
      $display("FAIL itype_imm: result=%h store=%h want 00000007 00000999", exmem_result, exmem_store);
    end
    set_idle();
  endtask

  task automatic test_alu_random();
    logic [31:0] prev;
    logic [31:0] a, bf, b;
    logic [35:0] exp_v;
    logic [1:0]  fa, fb;
    prev = '0;
    for (int i = 0; i < 40; i++) begin
      idex_op       = ($urandom_range(0, 1) == 0) ? R_TYPE : I_TYPE;
      idex_alu_op   = ops[$urandom_range(0, 10)];
      idex_rs1_data = 32'($urandom);
      idex_rs2_data = ($urandom_range(0, 4) == 0) ? idex_rs1_data : 32'($urandom);
      idex_imm      = 32'($urandom);
      memwb_data    = 32'($urandom);
      idex_f3       = 3'($urandom);
      idex_f7       = 7'b0;
      idex_valid    = 1'($urandom);
      idex_ctrl     = 5'($urandom);
      idex_rd       = 5'($urandom);
      fa = 2'($urandom_range(0, 3));
      fb = 2'($urandom_range(0, 3));
      if (i == 0 && fa == 2'b01) fa = 2'b00;
      if (i == 0 && fb == 2'b01) fb = 2'b00;
      forwardA = fa; forwardB = fb;
      a  = (fa == 2'b01) ? prev : (fa == 2'b10) ? memwb_data : idex_rs1_data;
      bf = (fb == 2'b01) ? prev : (fb == 2'b10) ? memwb_data : idex_rs2_data;
      b  = (idex_op == R_TYPE) ? bf : idex_imm;
      exp_v = model_alu(idex_alu_op, a, b);
      tick();
      checks++;
      if ({exmem_result, exmem_flags} !== exp_v) begin
        failures++;
        $display("FAIL alu_rand[%0d] op=%0d a=%h b=%h: result=%h flags=%b want %h %b",
                 i, idex_alu_op, a, b, exmem_result, exmem_flags, exp_v[35:4], exp_v[3:0]);
      end
      checks++;
      if ({exmem_valid, exmem_store, exmem_rd, exmem_ctrl} !==
          {idex_valid, bf, idex_rd, idex_valid ? idex_ctrl : 5'b0}) begin
        failures++;
        $display("FAIL fields_rand[%0d]: valid=%0d store=%h rd=%0d ctrl=%b want %0d %h %0d %b",
                 i, exmem_valid, exmem_store, exmem_rd, exmem_ctrl, idex_valid, bf, idex_rd,
                 idex_valid ? idex_ctrl : 5'b0);
      end
      prev = exp_v[35:4];
    end
    set_idle();
  endtask

  task automatic test_branch();
    logic [31:0] a, b;
    logic        exp_t;
    set_idle();
    drive(B_TYPE, ALU_SUB, 32'hFFFF_FFFB, 32'd3, 32'h20);
    idex_pc = 32'h100; idex_f3 = F3_BLT;
    #1;
    checks++;
    if ({branch_taken, branch_target} !== {1'b1, 32'h120}) begin
      failures++;
      $display("FAIL blt_taken: taken=%b target=%h want 1 00000120", branch_taken, branch_target);
    end
    idex_f3 = F3_BLTU;
    #1;
    checks++;
    if (branch_taken !== 1'b0) begin
      failures++; $display("FAIL bltu_not_taken: taken=%b want 0", branch_taken);
    end
    idex_f3 = F3_BLT; idex_valid = 1'b0;
    #1;
    checks++;
    if (branch_taken !== 1'b0) begin
      failures++; $display("FAIL branch_invalid: taken=%b want 0", branch_taken);
    end
    for (int i = 0; i < 16; i++) begin
      a = 32'($urandom);
      case ($urandom_range(0, 2))
        0:       b = a;
        1:       b = ~a;
        default: b = 32'($urandom);
      endcase
      idex_valid = 1'b1;
      idex_f3    = 3'($urandom);
      idex_pc    = 32'($urandom);
      idex_imm   = 32'($urandom);
      memwb_data = 32'($urandom);
      forwardA   = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
      forwardB   = 2'b00;
      idex_rs1_data = (forwardA == 2'b10) ? 32'($urandom) : a;
      if (forwardA == 2'b10) memwb_data = a;
      idex_rs2_data = b;
      exp_t = model_br(idex_f3, a, b);
      #1;
      checks++;
      if ({branch_taken, branch_target} !== {exp_t, idex_pc + idex_imm}) begin
        failures++;
        $display("FAIL branch_rand[%0d] f3=%b a=%h b=%h: taken=%b target=%h want %b %h",
                 i, idex_f3, a, b, branch_taken, branch_target, exp_t, idex_pc + idex_imm);
      end
    end
    set_idle();
    tick();
  endtask

  task automatic test_stall();
    set_idle();
    drive(R_TYPE, ALU_ADD, 32'd5, 32'd7, 32'h0);
    idex_ctrl = 5'b00100; idex_rd = 5'd3;
    tick();
    mem_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(R_TYPE, ALU_XOR, 32'($urandom), 32'($urandom), 32'($urandom));
      idex_ctrl = 5'($urandom); idex_rd = 5'($urandom);
      if (k == 2) begin
        drive(B_TYPE, ALU_ADD, 32'hFFFF_0000, 32'd12, 32'h40);
        idex_f3 = F3_BEQ; forwardA = 2'b01;
      end
      #1;
      checks++;
      if (ex_stall !== 1'b1) begin
        failures++; $display("FAIL stall_ex_stall[%0d]: got %b want 1", k, ex_stall);
      end
      if (k == 2) begin
        checks++;
        if (branch_taken !== 1'b1) begin
          failures++; $display("FAIL stall_fwd_exmem_branch: taken=%b want 1", branch_taken);
        end
      end
      tick();
      checks++;
      if ({exmem_valid, exmem_result, exmem_store, exmem_rd, exmem_ctrl} !==
          {1'b1, 32'd12, 32'd7, 5'd3, 5'b00100}) begin
        failures++;
        $display("FAIL stall_hold[%0d]: valid=%0d result=%h store=%h rd=%0d ctrl=%b want 1 0000000c 00000007 3 00100",
                 k, exmem_valid, exmem_result, exmem_store, exmem_rd, exmem_ctrl);
      end
    end
    mem_stall = 1'b0;
    #1;
    checks++;
    if (ex_stall !== 1'b0) begin
      failures++; $display("FAIL stall_release: ex_stall=%b want 0", ex_stall);
    end
    tick();
    checks++;
    if ({exmem_result, exmem_store} !== {32'd24, 32'd12}) begin
      failures++;
      $display("FAIL post_stall_capture: result=%h store=%h want 00000018 0000000c", exmem_result, exmem_store);
    end
    set_idle();
  endtask

  task automatic test_reset_mid();
    set_idle();
    drive(R_TYPE, ALU_ADD, 32'd1, 32'd2, 32'h0);
    idex_ctrl = 5'b00100; idex_rd = 5'd4;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({exmem_valid, exmem_result, exmem_store, exmem_rd, exmem_ctrl, exmem_flags} !== '0) begin
      failures++;
      $display("FAIL reset_mid_stream: valid=%0d result=%h store=%h rd=%0d ctrl=%b flags=%b, want all 0",
               exmem_valid, exmem_result, exmem_store, exmem_rd, exmem_ctrl, exmem_flags);
    end
`ifdef EX_MUL_EN
    drive(R_TYPE, ALU_ADD, 32'h0000_0003, 32'h0000_0005, 32'h0);
    idex_f7 = F7_MUL; idex_f3 = 3'b000;
    repeat (10) tick();
    rst = 1'b1; idex_valid = 1'b0;
    tick();
    rst = 1'b0;
    checks++;
    if ({exmem_valid, exmem_result, exmem_ctrl, exmem_flags, ex_stall} !== '0) begin
      failures++;
      $display("FAIL reset_mid_mul: valid=%0d result=%h ctrl=%b flags=%b ex_stall=%b, want all 0",
               exmem_valid, exmem_result, exmem_ctrl, exmem_flags, ex_stall);
    end
`endif
    set_idle();
  endtask

`ifdef EX_MUL_EN
  task automatic test_mul();
    int busy;
    set_idle();
    drive(R_TYPE, ALU_ADD, 32'h1234_5678, 32'h10, 32'h0);
    idex_f7 = F7_MUL; idex_f3 = 3'b000; idex_ctrl = 5'b00100; idex_rd = 5'd9;
    #1;
    busy = 0;
    while (ex_stall === 1'b1 && busy < 100) begin
      busy++;
      if (busy == 2) begin
        forwardA = 2'b10; memwb_data = 32'hFFFF_FFFF;
      end
      tick();
    end
    checks++;
    if (busy != 33) begin
      failures++; $display("FAIL mul_busy_cycles: got %0d want 33", busy);
    end
    checks++;
    if (exmem_valid !== 1'b0) begin
      failures++; $display("FAIL mul_bubble: exmem_valid=%b want 0", exmem_valid);
    end
    tick();
    checks++;
    if ({exmem_valid, exmem_result, exmem_flags, exmem_rd} !== {1'b1, 32'h2345_6780, 4'b0000, 5'd9}) begin
      failures++;
      $display("FAIL mul_result: valid=%0d result=%h flags=%b rd=%0d want 1 23456780 0000 9",
               exmem_valid, exmem_result, exmem_flags, exmem_rd);
    end
    idex_valid = 1'b0; forwardA = 2'b00;
    tick();
    checks++;
    if (exmem_valid !== 1'b0) begin
      failures++; $display("FAIL mul_one_cycle: exmem_valid=%b want 0", exmem_valid);
    end
    set_idle();
  endtask
`else
  task automatic test_mul();
    set_idle();
    drive(R_TYPE, ALU_ADD, 32'h1234_5678, 32'h10, 32'h0);
    idex_f7 = F7_MUL; idex_f3 = 3'b000;
    #1;
    checks++;
    if (ex_stall !== 1'b0) begin
      failures++; $display("FAIL mul_disabled_stall: ex_stall=%b want 0", ex_stall);
    end
    tick();
    checks++;
    if ({exmem_valid, exmem_result} !== {1'b1, 32'h1234_5688}) begin
      failures++;
      $display("FAIL mul_disabled_alu: valid=%0d result=%h want 1 12345688", exmem_valid, exmem_result);
    end
    set_idle();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_directed();
    test_alu_random();
    test_branch();
    test_stall();
    test_reset_mid();
    test_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
